ysyx_25040129_lsu: RTL and testbench
====================================

Name: ysyx_25040129_lsu

Overview:
Multi-cycle load/store unit that replaces the combinational memory stage. It takes one decoded instruction per handshake from EXU and computes addr = src1 + imm. It issues at most one request on a valid/ready memory bus, then aligns and sign/zero-extends the load data. It flags misaligned and timed-out accesses, and hands the result to WBU over a valid/ready handshake.

Parameters:
XLEN, 32, data and address width; legal values are 32 or 64.
TIMEOUT, 255, maximum cycles to wait for mem_resp_valid; 0 disables the timeout.

Ports:
clk  in  1  clock; all state is updated on the rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EXU holds a valid instruction
in_ready  out  1  LSU can accept an instruction; high only in IDLE
in_opcode  in  7  7'b0000011 = LOAD, 7'b0100011 = STORE, any other value = pass-through
in_funct3  in  3  access size and signedness
in_src1  in  XLEN  base address
in_imm  in  XLEN  offset
in_src2  in  XLEN  store data
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  XLEN  address aligned down to an XLEN/8 boundary
mem_req_wen  out  1  1 = write
mem_req_wstrb  out  XLEN/8  byte-lane strobe
mem_req_wdata  out  XLEN  store data shifted onto its byte lanes
mem_resp_valid  in  1  response valid; single-cycle pulse
mem_resp_rdata  in  XLEN  read data for the full aligned word
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts the result
out_rdata  out  XLEN  extended load data; 0 for stores and pass-through
out_err  out  2  0 = ok, 1 = misaligned, 2 = timeout

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE.
  - mem_req_valid, out_valid, out_rdata, out_err, mem_req_* outputs all reset to 0.
  - in_ready = 1.
  - Timeout counter cleared.
  - An in-flight request is abandoned without notice; a response arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on in_valid & in_ready, latch all inputs and compute addr and offset = addr[log2(XLEN/8)-1:0].
  - Pass-through opcode, or illegal funct3 → DONE, out_err = 0. Illegal funct3 for loads: 3,6,7 when XLEN=32; 7 when XLEN=64. For stores: >3, or 3 when XLEN=32.
  - Misaligned → DONE, out_err = 1, and no bus request is issued. Misaligned means: halfword with addr[0] set; word with addr[1:0] ≠ 0; doubleword with addr[2:0] ≠ 0.
  - Otherwise → REQ.
- Load decode (funct3): LB 0, LH 1, LW 2, LD 3 (XLEN=64 only), LBU 4, LHU 5, LWU 6 (XLEN=64 only).
- Store decode (funct3): SB 0, SH 1, SW 2, SD 3 (XLEN=64 only).
- REQ: mem_req_valid = 1 and all mem_req_* fields are held stable until mem_req_ready. On the handshake cycle → WAIT and clear the counter.
  - wstrb = size mask << offset.
  - wdata = src2 << (8*offset).
- WAIT: on mem_resp_valid → DONE.
  - Loads: out_rdata = extend(rdata >> (8*offset)). Stores ignore rdata.
  - Otherwise the counter increments each cycle. When TIMEOUT ≠ 0 and the counter equals TIMEOUT−1 without a response → DONE with out_err = 2, out_rdata = 0.
  - A response in the same cycle as the timeout wins; out_err = 0.
- DONE: out_valid = 1 and outputs are held stable until out_ready, then → IDLE.
- Latency: earliest in_valid-to-out_valid is 3 cycles, reached when mem_req_ready is already high and the response comes on the following cycle. Pass-through and misaligned complete in 1 cycle.
- Throughput: one instruction in flight; no back-to-back acceptance while out_valid is held.
- mem_resp_valid outside WAIT is ignored.
- Address arithmetic wraps modulo 2^XLEN.

Decomposition:
- Shared package ysyx_25040129_lsu_pkg:
  - opcode constants OP_LOAD and OP_STORE.
  - funct3 encodings.
  - state enum.
  - out_err encodings ERR_OK, ERR_MISALIGN, ERR_TIMEOUT.
- One natural sub-module: ysyx_25040129_lsu_align. It is combinational: it takes offset, funct3 and data and produces wstrb, shifted wdata and extended rdata. It is reused by a later cache.

Test Plan:
- LW, XLEN=32: src1 = 0x8000_0000, imm = 4; memory ready immediately, response with 0xDEAD_BEEF one cycle later.
  → mem_req_addr = 0x8000_0004, wen = 0; out_rdata = 0xDEAD_BEEF, out_err = 0; out_valid exactly 3 cycles after accept.
- LB at addr 0x8000_0003, rdata = 0x8000_0000 → out_rdata = 0xFFFF_FF80.
  LBU at the same address → out_rdata = 0x0000_0080.
- SH: addr 0x8000_0002, src2 = 0x1234_ABCD → wstrb = 4'b1100, wdata = 0xABCD_0000, wen = 1.
  Hold mem_req_ready low 5 cycles → all request fields remain stable throughout.
- LW at 0x8000_0001 → no mem_req_valid ever asserted; out_err = 1 one cycle after accept.
- TIMEOUT = 4, no response → out_err = 2 four cycles after the request handshake; a late mem_resp_valid is ignored and the next instruction completes normally.
- Reset mid-WAIT: drop rst_n → immediately out_valid = 0, in_ready = 1, mem_req_valid = 0; the following instruction completes correctly.
- Backpressure: out_ready low 3 cycles → out_valid and out_rdata held stable; in_ready stays 0 throughout.

Source files
------------

// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared definitions for the load/store unit: opcodes, funct3 encodings,
// FSM states, error codes and decode helpers.
package ysyx_25040129_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    // Doubleword and unsigned-word accesses only exist on a 64-bit datapath.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] funct3, input int xlen);
        logic ok;
        if (is_store) begin
            ok = !funct3[2] && ((funct3 != F3_D) || (xlen == 64));
        end else begin
            case (funct3)
                F3_D, F3_WU: ok = (xlen == 64);
                3'd7:        ok = 1'b0;
                default:     ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25040129_lsu_if.sv
// Memory request/response bus between the load/store unit (master) and memory (slave).
interface ysyx_25040129_lsu_if #(
    parameter int XLEN = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [XLEN-1:0]     mem_req_addr;
    logic                mem_req_wen;
    logic [XLEN/8-1:0]   mem_req_wstrb;
    logic [XLEN-1:0]     mem_req_wdata;
    logic                mem_resp_valid;
    logic [XLEN-1:0]     mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational byte-lane alignment: store strobe/data placement and load
// data extraction with sign or zero extension.
module ysyx_25040129_lsu_align
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [2:0]                funct3,
    input  logic [XLEN-1:0]           wdata_in,
    input  logic [XLEN-1:0]           rdata_in,
    output logic [XLEN/8-1:0]         wstrb,
    output logic [XLEN-1:0]           wdata,
    output logic [XLEN-1:0]           rdata
);
    localparam int STRB_W = XLEN / 8;

    logic [STRB_W-1:0] size_mask;
    logic [XLEN-1:0]   rshift;

    always_comb begin
        case (funct3[1:0])
            2'd0:    size_mask = STRB_W'(8'h01);
            2'd1:    size_mask = STRB_W'(8'h03);
            2'd2:    size_mask = STRB_W'(8'h0f);
            default: size_mask = '1;
        endcase
        wstrb  = size_mask << offset;
        wdata  = wdata_in << {offset, 3'b000};
        rshift = rdata_in >> {offset, 3'b000};

        // Width casts of signed slices sign-extend; unsigned slices zero-extend.
        case (funct3)
            F3_B:    rdata = XLEN'(signed'(rshift[7:0]));
            F3_H:    rdata = XLEN'(signed'(rshift[15:0]));
            F3_W:    rdata = XLEN'(signed'(rshift[31:0]));
            F3_BU:   rdata = XLEN'(rshift[7:0]);
            F3_HU:   rdata = XLEN'(rshift[15:0]);
            F3_WU:   rdata = XLEN'(rshift[31:0]);
            default: rdata = rshift;
        endcase
    end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Multi-cycle load/store unit: one instruction in flight, at most one bus
// request per instruction, with misalignment and response-timeout reporting.
module ysyx_25040129_lsu
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int          XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_src2,
    ysyx_25040129_lsu_if.master mem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rdata,
    output logic [1:0]       out_err
);
    localparam int OFF_W  = $clog2(XLEN / 8);
    localparam int STRB_W = XLEN / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_reg, state_next;
    logic [2:0]          funct3_reg;
    logic                is_load_reg;
    logic [OFF_W-1:0]    offset_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [XLEN-1:0]     req_addr_reg;
    logic                req_wen_reg;
    logic [STRB_W-1:0]   req_wstrb_reg;
    logic [XLEN-1:0]     req_wdata_reg;
    logic [XLEN-1:0]     rdata_reg;
    logic [1:0]          err_reg;

    logic [XLEN-1:0]     addr;
    logic                is_load, is_store, legal, misalign, accept, timeout_hit;
    logic [OFF_W-1:0]    align_offset;
    logic [2:0]          align_funct3;
    logic [STRB_W-1:0]   align_wstrb;
    logic [XLEN-1:0]     align_wdata, align_rdata;

    assign addr        = in_src1 + in_imm;
    assign is_load     = (in_opcode == OP_LOAD);
    assign is_store    = (in_opcode == OP_STORE);
    assign legal       = (is_load || is_store) && f3_legal(is_store, in_funct3, XLEN);
    assign misalign    = misaligned(in_funct3, addr[2:0]);
    assign accept      = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    assign in_ready          = (state_reg == S_IDLE);
    assign out_valid         = (state_reg == S_DONE);
    assign out_rdata         = rdata_reg;
    assign out_err           = err_reg;
    assign mem.mem_req_valid = (state_reg == S_REQ);
    assign mem.mem_req_addr  = req_addr_reg;
    assign mem.mem_req_wen   = req_wen_reg;
    assign mem.mem_req_wstrb = req_wstrb_reg;
    assign mem.mem_req_wdata = req_wdata_reg;

    // One aligner serves both directions: live inputs while idle for store
    // placement, latched offset/funct3 afterwards for load extraction.
    assign align_offset = (state_reg == S_IDLE) ? addr[OFF_W-1:0] : offset_reg;
    assign align_funct3 = (state_reg == S_IDLE) ? in_funct3 : funct3_reg;

    ysyx_25040129_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .offset   (align_offset),
        .funct3   (align_funct3),
        .wdata_in (in_src2),
        .rdata_in (mem.mem_resp_rdata),
        .wstrb    (align_wstrb),
        .wdata    (align_wdata),
        .rdata    (align_rdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = (!legal || misalign) ? S_DONE : S_REQ;
            S_REQ:  if (mem.mem_req_ready) state_next = S_WAIT;
            S_WAIT: if (mem.mem_resp_valid || timeout_hit) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            funct3_reg    <= '0;
            is_load_reg   <= 1'b0;
            offset_reg    <= '0;
            cnt_reg       <= '0;
            req_addr_reg  <= '0;
            req_wen_reg   <= 1'b0;
            req_wstrb_reg <= '0;
            req_wdata_reg <= '0;
            rdata_reg     <= '0;
            err_reg       <= ERR_OK;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        funct3_reg  <= in_funct3;
                        is_load_reg <= is_load;
                        offset_reg  <= addr[OFF_W-1:0];
                        rdata_reg   <= '0;
                        err_reg     <= (legal && misalign) ? ERR_MISALIGN : ERR_OK;
                        if (legal && !misalign) begin
                            req_addr_reg  <= {addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            req_wen_reg   <= is_store;
                            req_wstrb_reg <= align_wstrb;
                            req_wdata_reg <= align_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) cnt_reg <= '0;
                end
                S_WAIT: begin
                    // A response on the final counted cycle still wins over the timeout.
                    if (mem.mem_resp_valid) begin
                        rdata_reg <= is_load_reg ? align_rdata : '0;
                    end else if (timeout_hit) begin
                        err_reg <= ERR_TIMEOUT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Directed bench for the load/store unit: a transaction-level model predicts
// the bus request, result and latency; a per-cycle monitor compares against it.
module tb_ysyx_25040129_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_src1, in_imm, in_src2;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic [1:0]  out_err;

    ysyx_25040129_lsu_if #(.XLEN(32)) mem_if ();

    ysyx_25040129_lsu #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_src1   (in_src1),
        .in_imm    (in_imm),
        .in_src2   (in_src2),
        .mem       (mem_if),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state for the instruction currently in flight.
    bit          busy = 1'b0;
    bit          exp_mem, exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_err;
    int          exp_lat;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic predict(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] s1, imm, s2, rd,
                           input int rdly, input int rsp);
        logic [31:0] a;
        int          off, nbytes;
        bit          ld, st, legal, tmo;
        longint      v;
        a      = s1 + imm;
        off    = int'(a % 4);
        nbytes = 1 << (f3 % 4);
        ld     = (op == 7'b0000011);
        st     = (op == 7'b0100011);
        legal  = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (st ? (f3 <= 3'd2) : 1'b0);
        tmo    = !(rsp >= 0 && rsp < TO);
        exp_mem = 0; exp_wen = 0; exp_addr = 0; exp_strb = 0; exp_wdata = 0;
        exp_rdata = 0; exp_err = 0; exp_lat = 1;
        if (legal && (a % nbytes) != 0) begin
            exp_err = 2'd1;
        end else if (legal) begin
            exp_mem   = 1;
            exp_addr  = a - off;
            exp_wen   = st;
            exp_strb  = 4'(((1 << nbytes) - 1) << off);
            exp_wdata = s2 << (8 * off);
            exp_err   = tmo ? 2'd2 : 2'd0;
            exp_lat   = tmo ? (rdly + 2 + TO) : (rdly + rsp + 3);
            if (ld && !tmo) begin
                v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * nbytes)) - 1);
                if (f3 < 3'd4 && v >= (longint'(1) << (8 * nbytes - 1)))
                    v -= longint'(1) << (8 * nbytes);
                exp_rdata = v[31:0];
            end
        end
    endtask

    // Issue one instruction and play memory/WBU. rsp < 0 means no response;
    // reset_at > 0 asserts reset in that cycle after acceptance.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] s1, imm, s2, rd,
                             input int rdly, input int rsp, input int ordly, input int reset_at,
                             output int lat, output int req_n, output logic [31:0] q_addr, q_wdata, q_rdata,
                             output logic [3:0] q_strb, output logic q_wen, output logic [1:0] q_err);
        bit fin;
        int hs, out_n, k;
        predict(op, f3, s1, imm, s2, rd, rdly, rsp);
        lat = -1; req_n = 0; q_addr = 0; q_wdata = 0; q_rdata = 0; q_strb = 0; q_wen = 0; q_err = 0;
        mem_if.mem_resp_rdata = rd;
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_src1 = s1; in_imm = imm; in_src2 = s2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy = 1'b1;
        hs = -1; out_n = 0; fin = 0; k = 1;
        while (!fin && k < 64) begin
            mem_if.mem_resp_valid = (hs >= 0 && rsp >= 0 && k == hs + 1 + rsp);
            mem_if.mem_req_ready  = 1'b0;
            if (mem_if.mem_req_valid) begin
                req_n++;
                if (req_n == 1) begin
                    q_addr = mem_if.mem_req_addr; q_wdata = mem_if.mem_req_wdata;
                    q_strb = mem_if.mem_req_wstrb; q_wen = mem_if.mem_req_wen;
                end
                if (req_n - 1 >= rdly) begin
                    mem_if.mem_req_ready = 1'b1;
                    hs = k;
                end
            end
            out_ready = 1'b0;
            if (out_valid) begin
                out_n++;
                if (out_n == 1) begin
                    lat = k; q_rdata = out_rdata; q_err = out_err;
                end
                if (out_n - 1 >= ordly) out_ready = 1'b1;
            end
            if (k == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_req_valid", mem_if.mem_req_valid, 0);
                busy = 1'b0;
                mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
                @(negedge clk); rst_n = 1'b1;
                @(posedge clk); #1;
                mem_if.mem_resp_valid = 1'b1;
                @(posedge clk); #1;
                mem_if.mem_resp_valid = 1'b0;
                fin = 1;
            end else begin
                @(posedge clk); #1;
                if (out_ready) begin
                    fin = 1; busy = 1'b0; out_ready = 1'b0;
                end
                k++;
            end
        end
        mem_if.mem_req_ready = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        chk("completion_bound", fin, 1);
        if (reset_at == 0) begin
            chk("latency", lat, exp_lat);
            chk("req_cycles", req_n, exp_mem ? rdly + 1 : 0);
        end
        $display("txn op=%h f3=%0d addr=%h -> rdata=%h err=%0d lat=%0d req_cycles=%0d",
                 op, f3, s1 + imm, q_rdata, q_err, lat, req_n);
    endtask

    // Per-cycle monitor against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("in_ready", in_ready, !busy);
                if (!busy) begin
                    chk("idle_req_valid", mem_if.mem_req_valid, 0);
                    chk("idle_out_valid", out_valid, 0);
                end else begin
                    if (!exp_mem) chk("no_req", mem_if.mem_req_valid, 0);
                    if (mem_if.mem_req_valid) begin
                        chk("req_addr", mem_if.mem_req_addr, exp_addr);
                        chk("req_wen", mem_if.mem_req_wen, exp_wen);
                        chk("req_wstrb", mem_if.mem_req_wstrb, exp_strb);
                        chk("req_wdata", mem_if.mem_req_wdata, exp_wdata);
                    end
                    if (out_valid) begin
                        chk("out_rdata", out_rdata, exp_rdata);
                        chk("out_err", out_err, exp_err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    int          lat, rn;
    logic [31:0] qa, qw, qr;
    logic [3:0]  qs;
    logic        qwen;
    logic [1:0]  qe;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = 0; in_funct3 = 0;
        in_src1 = 0; in_imm = 0; in_src2 = 0; out_ready = 1'b0;
        mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_req_valid", mem_if.mem_req_valid, 0);
        chk("reset_out_rdata", out_rdata, 0);
        chk("reset_out_err", out_err, 0);
        chk("reset_req_addr", mem_if.mem_req_addr, 0);
        chk("reset_req_wstrb", mem_if.mem_req_wstrb, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(7'b0000011, 3'd2, 32'h8000_0000, 32'd4, 0, 32'hDEAD_BEEF, 0, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("lw_addr", qa, 32'h8000_0004);
        chk("lw_wen", qwen, 0);
        chk("lw_rdata", qr, 32'hDEAD_BEEF);
        chk("lw_err", qe, 0);
        chk("lw_lat", lat, 3);

        run_instr(7'b0000011, 3'd0, 32'h8000_0000, 32'd3, 0, 32'h8000_0000, 0, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("lb_rdata", qr, 32'hFFFF_FF80);
        run_instr(7'b0000011, 3'd4, 32'h8000_0000, 32'd3, 0, 32'h8000_0000, 0, 1, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("lbu_rdata", qr, 32'h0000_0080);

        run_instr(7'b0100011, 3'd1, 32'h8000_0000, 32'd2, 32'h1234_ABCD, 0, 5, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("sh_wstrb", qs, 4'b1100);
        chk("sh_wdata", qw, 32'hABCD_0000);
        chk("sh_wen", qwen, 1);
        chk("sh_req_cycles", rn, 6);

        run_instr(7'b0000011, 3'd2, 32'h8000_0001, 0, 0, 0, 0, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("mis_err", qe, 1);
        chk("mis_lat", lat, 1);
        chk("mis_req", rn, 0);

        // Response arrives only after DONE has been entered: must be ignored.
        run_instr(7'b0000011, 3'd2, 32'h8000_0010, 0, 0, 32'h5555_5555, 0, 4, 2, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("to_err", qe, 2);
        chk("to_rdata", qr, 0);
        chk("to_lat", lat, 6);

        run_instr(7'b0000011, 3'd5, 32'h8000_0006, 0, 0, 32'hABCD_1234, 1, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("lhu_rdata", qr, 32'h0000_ABCD);
        run_instr(7'b0000011, 3'd1, 32'h8000_0004, 32'd2, 0, 32'hABCD_1234, 0, 2, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("lh_rdata", qr, 32'hFFFF_ABCD);

        // Response on the last counted cycle beats the timeout.
        run_instr(7'b0100011, 3'd0, 32'h8000_0001, 0, 32'h0000_0055, 0, 0, 3, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("sb_err", qe, 0);
        chk("sb_wstrb", qs, 4'b0010);
        chk("sb_wdata", qw, 32'h0000_5500);
        chk("sb_lat", lat, 6);

        run_instr(7'b0110011, 3'd0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("pass_lat", lat, 1);
        chk("pass_err", qe, 0);
        run_instr(7'b0000011, 3'd3, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("ld_illegal_req", rn, 0);
        run_instr(7'b0100011, 3'd4, 32'h8000_0000, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("st_illegal_err", qe, 0);

        run_instr(7'b0000011, 3'd2, 32'h8000_0020, 0, 0, 0, 0, -1, 0, 3,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        run_instr(7'b0000011, 3'd2, 32'hFFFF_FFFC, 32'd8, 0, 32'h1122_3344, 0, 0, 0, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("wrap_addr", qa, 32'h0000_0004);
        chk("wrap_rdata", qr, 32'h1122_3344);

        run_instr(7'b0000011, 3'd1, 32'h8000_0000, 0, 0, 32'h0000_8001, 0, 0, 3, 0,
                  lat, rn, qa, qw, qr, qs, qwen, qe);
        chk("bp_rdata", qr, 32'hFFFF_8001);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
